// File: rtl/ami_client_mux.sv
// Round-robin multiplexer of NUM_CLIENTS AMI request channels onto one memory port, with
// in-order read responses steered back through a client-ID tag FIFO. Counters: AMI_MUX_PERF_EN.
module ami_client_mux #(
    parameter int NUM_CLIENTS = 2,
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 512,
    parameter int TAG_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CLIENTS-1:0]        cli_req_valid,
    input  logic [NUM_CLIENTS-1:0]        cli_req_is_write,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] cli_req_addr,
    input  logic [NUM_CLIENTS*DATA_W-1:0] cli_req_data,
    output logic [NUM_CLIENTS-1:0]        cli_req_grant,
    output logic [NUM_CLIENTS-1:0]        cli_resp_valid,
    output logic [DATA_W-1:0]             cli_resp_data,
    input  logic [NUM_CLIENTS-1:0]        cli_resp_grant,
    output logic                          mem_req_valid,
    output logic                          mem_req_is_write,
    output logic [ADDR_W-1:0]             mem_req_addr,
    output logic [DATA_W-1:0]             mem_req_data,
    input  logic                          mem_req_grant,
    input  logic                          mem_resp_valid,
    input  logic [DATA_W-1:0]             mem_resp_data,
    output logic                          mem_resp_grant,
    output logic [$clog2(TAG_DEPTH):0]    outstanding_rd,
    output logic                          resp_err,
    output logic [31:0]                   perf_rd_cnt,
    output logic [31:0]                   perf_wr_cnt,
    output logic [31:0]                   perf_stall_cnt
);

    localparam int CID_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CNT_W = $clog2(TAG_DEPTH) + 1;

    logic                   vld_p1;
    logic                   wr_p1;
    logic [ADDR_W-1:0]      addr_p1;
    logic [DATA_W-1:0]      data_p1;

    logic [CID_W-1:0]       rr_ptr;
    logic [CID_W-1:0]       tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       tag_cnt;
    logic                   err_q;

    logic                   tag_full;
    logic                   tag_empty;
    logic                   slot_free;
    logic                   load;
    logic                   push;
    logic                   pop;
    logic [NUM_CLIENTS-1:0] eligible;
    logic [NUM_CLIENTS-1:0] grant;
    logic [CID_W-1:0]       win;
    logic                   win_vld;
    logic [CID_W-1:0]       head;

    function automatic logic [CID_W-1:0] rr_index(input logic [CID_W-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_CLIENTS) sum = sum - NUM_CLIENTS;
        return CID_W'(sum);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (int'(p) == TAG_DEPTH - 1) ? '0 : p + PTR_W'(1);
    endfunction

    // Arbitration: reads are held back while every tag slot is in use
    assign tag_full  = (tag_cnt == CNT_W'(TAG_DEPTH));
    assign tag_empty = (tag_cnt == '0);
    assign slot_free = ~vld_p1 | mem_req_grant;
    assign eligible  = cli_req_valid & (cli_req_is_write | {NUM_CLIENTS{~tag_full}});

    // Scanning from the far end down lets the client nearest rr_ptr win the final write.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
            if (eligible[rr_index(rr_ptr, k)]) begin
                win     = rr_index(rr_ptr, k);
                win_vld = 1'b1;
            end
        end
    end

    assign load = win_vld & slot_free & ~reset;
    assign push = load & ~cli_req_is_write[win];

    always_comb begin
        grant = '0;
        if (load) grant[win] = 1'b1;
    end

    assign cli_req_grant = grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (load) begin
            rr_ptr <= rr_index(win, 1);
        end
    end

    // Stage p1: registered memory request slot
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1 <= 1'b0;
        end else if (load) begin
            vld_p1 <= 1'b1;
        end else if (mem_req_grant) begin
            vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            wr_p1   <= cli_req_is_write[win];
            addr_p1 <= cli_req_addr[int'(win)*ADDR_W +: ADDR_W];
            data_p1 <= cli_req_data[int'(win)*DATA_W +: DATA_W];
        end
    end

    assign mem_req_valid    = vld_p1;
    assign mem_req_is_write = wr_p1;
    assign mem_req_addr     = addr_p1;
    assign mem_req_data     = data_p1;

    // Tag FIFO: one client ID per read in flight, popped as responses are consumed
    assign head = tag_mem[rd_ptr];
    assign pop  = mem_resp_valid & ~tag_empty & cli_resp_grant[head];

    always_ff @(posedge clk) begin
        if (push) tag_mem[wr_ptr] <= win;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            tag_cnt <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   tag_cnt <= tag_cnt + CNT_W'(1);
                2'b01:   tag_cnt <= tag_cnt - CNT_W'(1);
                default: tag_cnt <= tag_cnt;
            endcase
        end
    end

    assign outstanding_rd = tag_cnt;

    // A response with no tag to match is swallowed so the memory side cannot stall on it.
    always_comb begin
        cli_resp_valid = '0;
        if (!tag_empty) cli_resp_valid[head] = mem_resp_valid;
    end

    assign cli_resp_data  = mem_resp_data;
    assign mem_resp_grant = tag_empty ? mem_resp_valid : cli_resp_grant[head];

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (mem_resp_valid && tag_empty) begin
            err_q <= 1'b1;
        end
    end

    assign resp_err = err_q;

`ifdef AMI_MUX_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;
    logic [31:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            stall_cnt <= '0;
        end else begin
            if (vld_p1 && mem_req_grant && !wr_p1) rd_cnt <= sat_inc(rd_cnt);
            if (vld_p1 && mem_req_grant && wr_p1)  wr_cnt <= sat_inc(wr_cnt);
            if (vld_p1 && !mem_req_grant)          stall_cnt <= sat_inc(stall_cnt);
        end
    end

    assign perf_rd_cnt    = rd_cnt;
    assign perf_wr_cnt    = wr_cnt;
    assign perf_stall_cnt = stall_cnt;
`else
    assign perf_rd_cnt    = '0;
    assign perf_wr_cnt    = '0;
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ami_client_mux.sv
// Directed bench for ami_client_mux: bench-side memory model plus a response scoreboard
// keyed by the client that issued each read.
module tb_ami_client_mux;

    localparam int NC = 2;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TD = 4;

`ifdef AMI_MUX_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [NC-1:0]     cli_req_valid;
    logic [NC-1:0]     cli_req_is_write;
    logic [NC*AW-1:0]  cli_req_addr;
    logic [NC*DW-1:0]  cli_req_data;
    logic [NC-1:0]     cli_req_grant;
    logic [NC-1:0]     cli_resp_valid;
    logic [DW-1:0]     cli_resp_data;
    logic [NC-1:0]     cli_resp_grant;
    logic              mem_req_valid;
    logic              mem_req_is_write;
    logic [AW-1:0]     mem_req_addr;
    logic [DW-1:0]     mem_req_data;
    logic              mem_req_grant;
    logic              mem_resp_valid;
    logic [DW-1:0]     mem_resp_data;
    logic              mem_resp_grant;
    logic [$clog2(TD):0] outstanding_rd;
    logic              resp_err;
    logic [31:0]       perf_rd_cnt;
    logic [31:0]       perf_wr_cnt;
    logic [31:0]       perf_stall_cnt;

    typedef struct {
        int            cid;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    logic [AW-1:0] mem_q[$];
    int            checks = 0;
    int            errors = 0;
    logic          resp_en;
    int            seq [NC];
    logic [NC-1:0] last_gnt;
    logic [NC-1:0] last_crv;
    logic          last_mrg;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;

    ami_client_mux #(
        .NUM_CLIENTS(NC),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .TAG_DEPTH  (TD)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .cli_req_valid   (cli_req_valid),
        .cli_req_is_write(cli_req_is_write),
        .cli_req_addr    (cli_req_addr),
        .cli_req_data    (cli_req_data),
        .cli_req_grant   (cli_req_grant),
        .cli_resp_valid  (cli_resp_valid),
        .cli_resp_data   (cli_resp_data),
        .cli_resp_grant  (cli_resp_grant),
        .mem_req_valid   (mem_req_valid),
        .mem_req_is_write(mem_req_is_write),
        .mem_req_addr    (mem_req_addr),
        .mem_req_data    (mem_req_data),
        .mem_req_grant   (mem_req_grant),
        .mem_resp_valid  (mem_resp_valid),
        .mem_resp_data   (mem_resp_data),
        .mem_resp_grant  (mem_resp_grant),
        .outstanding_rd  (outstanding_rd),
        .resp_err        (resp_err),
        .perf_rd_cnt     (perf_rd_cnt),
        .perf_wr_cnt     (perf_wr_cnt),
        .perf_stall_cnt  (perf_stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        return {a ^ 16'h5A5A, a};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_addr(input int i);
        cli_req_addr[i*AW +: AW] = AW'(32'h1000 * (i + 1) + seq[i]);
        cli_req_data[i*DW +: DW] = 32'hC0DE_0000 | (i << 8) | seq[i];
    endtask

    // One clock: present memory response, record handshakes, score delivered responses.
    task automatic cycle();
        exp_t e;
        if (resp_en && mem_q.size() > 0) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = mem_fn(mem_q[0]);
        end else begin
            mem_resp_valid = 1'b0;
            mem_resp_data  = '0;
        end
        #1;
        last_gnt = cli_req_valid & cli_req_grant;
        last_crv = cli_resp_valid;
        last_mrg = mem_resp_grant;
        for (int i = 0; i < NC; i++) begin
            if (cli_req_valid[i] && cli_req_grant[i] && !cli_req_is_write[i]) begin
                e.cid  = i;
                e.data = mem_fn(cli_req_addr[i*AW +: AW]);
                exp_q.push_back(e);
            end
        end
        if (mem_req_valid && mem_req_grant && !mem_req_is_write) mem_q.push_back(mem_req_addr);
        if (mem_resp_valid && mem_resp_grant && mem_q.size() > 0) void'(mem_q.pop_front());
        if ((cli_resp_valid & cli_resp_grant) != '0) begin
            if (exp_q.size() == 0) begin
                chk("resp_unexpected", 64'(cli_resp_valid), 64'(0));
            end else begin
                e = exp_q.pop_front();
                chk("resp_client", 64'(cli_resp_valid), 64'(1 << e.cid));
                chk("resp_data", 64'(cli_resp_data), 64'(e.data));
            end
        end
        @(negedge clk);
        for (int i = 0; i < NC; i++) begin
            if (last_gnt[i]) begin
                seq[i]++;
                set_addr(i);
            end
        end
    endtask

    task automatic do_reset();
        reset            = 1'b1;
        cli_req_valid    = '0;
        cli_req_is_write = '0;
        cli_resp_grant   = '1;
        mem_req_grant    = 1'b0;
        mem_resp_valid   = 1'b0;
        mem_resp_data    = '0;
        resp_en          = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        mem_q.delete();
    endtask

    task automatic drain(input string tag);
        int n;
        n              = 0;
        resp_en        = 1'b1;
        cli_resp_grant = '1;
        cli_req_valid  = '0;
        mem_req_grant  = 1'b1;
        while ((exp_q.size() > 0 || outstanding_rd != 0) && n < 40) begin
            cycle();
            n++;
        end
        chk({tag, "_drained"}, 64'(exp_q.size()), 64'(0));
        chk({tag, "_outstanding"}, 64'(outstanding_rd), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete within time bound");
        $fatal(1, "timeout");
    end

    initial begin
        cli_req_addr   = '0;
        cli_req_data   = '0;
        mem_resp_data  = '0;
        for (int i = 0; i < NC; i++) begin
            seq[i] = 0;
            set_addr(i);
        end
        do_reset();
        #1;
        chk("rst_mem_req_valid", 64'(mem_req_valid), 64'(0));
        chk("rst_grant", 64'(cli_req_grant), 64'(0));
        chk("rst_resp_valid", 64'(cli_resp_valid), 64'(0));
        chk("rst_outstanding", 64'(outstanding_rd), 64'(0));
        chk("rst_resp_err", 64'(resp_err), 64'(0));
        chk("rst_perf_rd", 64'(perf_rd_cnt), 64'(0));
        chk("rst_perf_wr", 64'(perf_wr_cnt), 64'(0));
        chk("rst_perf_stall", 64'(perf_stall_cnt), 64'(0));

        // Stray response with nothing outstanding
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hDEAD_BEEF;
        #1;
        chk("err_drop_grant", 64'(mem_resp_grant), 64'(1));
        chk("err_no_cli_valid", 64'(cli_resp_valid), 64'(0));
        @(negedge clk);
        mem_resp_valid = 1'b0;
        chk("err_set", 64'(resp_err), 64'(1));
        repeat (3) @(negedge clk);
        chk("err_sticky", 64'(resp_err), 64'(1));
        do_reset();
        #1;
        chk("err_cleared", 64'(resp_err), 64'(0));

        // Two clients reading back to back
        mem_req_grant    = 1'b1;
        resp_en          = 1'b1;
        cli_req_valid    = 2'b11;
        cli_req_is_write = 2'b00;
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("rr_grant", 64'(last_gnt), (k % 2 == 0) ? 64'(1) : 64'(2));
        end
        drain("rr");

        // Tag FIFO full: reads blocked, writes still pass
        do_reset();
        mem_req_grant    = 1'b1;
        cli_req_valid    = 2'b01;
        cli_req_is_write = 2'b00;
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk("full_rd_grant", 64'(last_gnt), (k < 4) ? 64'(1) : 64'(0));
        end
        chk("full_outstanding", 64'(outstanding_rd), 64'(4));
        cli_req_valid    = 2'b11;
        cli_req_is_write = 2'b10;
        ra = cli_req_addr[AW +: AW];
        rd = cli_req_data[DW +: DW];
        cycle();
        chk("full_wr_grant", 64'(last_gnt), 64'(2));
        chk("wr_mem_valid", 64'(mem_req_valid), 64'(1));
        chk("wr_mem_is_write", 64'(mem_req_is_write), 64'(1));
        chk("wr_mem_addr", 64'(mem_req_addr), 64'(ra));
        chk("wr_mem_data", 64'(mem_req_data), 64'(rd));
        cli_req_valid = 2'b01;
        cycle();
        chk("full_still_blocked", 64'(last_gnt), 64'(0));
        chk("full_outstanding_after_wr", 64'(outstanding_rd), 64'(4));
        chk("perf_rd_4", 64'(perf_rd_cnt), PERF_ON ? 64'(4) : 64'(0));
        chk("perf_wr_1", 64'(perf_wr_cnt), PERF_ON ? 64'(1) : 64'(0));
        drain("full");

        // Memory back-pressure holds the slot steady
        do_reset();
        cli_req_valid    = 2'b01;
        cli_req_is_write = 2'b00;
        ra = cli_req_addr[0 +: AW];
        rd = cli_req_data[0 +: DW];
        cycle();
        chk("stall_load_grant", 64'(last_gnt), 64'(1));
        cli_req_valid = 2'b10;
        for (int k = 0; k < 5; k++) begin
            chk("stall_valid", 64'(mem_req_valid), 64'(1));
            chk("stall_addr", 64'(mem_req_addr), 64'(ra));
            chk("stall_data", 64'(mem_req_data), 64'(rd));
            cycle();
            chk("stall_no_grant", 64'(last_gnt), 64'(0));
        end
        chk("perf_stall_5", 64'(perf_stall_cnt), PERF_ON ? 64'(5) : 64'(0));
        mem_req_grant = 1'b1;
        cycle();
        chk("stall_release_grant", 64'(last_gnt), 64'(2));
        chk("perf_stall_hold", 64'(perf_stall_cnt), PERF_ON ? 64'(5) : 64'(0));
        chk("perf_rd_1", 64'(perf_rd_cnt), PERF_ON ? 64'(1) : 64'(0));
        drain("stall");

        // Client 1 delays accepting its response
        do_reset();
        mem_req_grant    = 1'b1;
        cli_req_valid    = 2'b10;
        cli_req_is_write = 2'b00;
        cycle();
        chk("hold_req_grant", 64'(last_gnt), 64'(2));
        cli_req_valid = 2'b00;
        cycle();
        resp_en        = 1'b1;
        cli_resp_grant = 2'b01;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("hold_cli_valid", 64'(last_crv), 64'(2));
            chk("hold_mem_grant", 64'(last_mrg), 64'(0));
            chk("hold_outstanding", 64'(outstanding_rd), 64'(1));
        end
        cli_resp_grant = 2'b11;
        cycle();
        chk("hold_pop_grant", 64'(last_mrg), 64'(1));
        chk("hold_popped", 64'(outstanding_rd), 64'(0));
        chk("hold_scoreboard_empty", 64'(exp_q.size()), 64'(0));

        // Reset with reads in flight
        do_reset();
        mem_req_grant    = 1'b1;
        cli_req_valid    = 2'b01;
        cli_req_is_write = 2'b00;
        repeat (3) cycle();
        chk("inflight_outstanding", 64'(outstanding_rd), 64'(3));
        chk("inflight_slot", 64'(mem_req_valid), 64'(1));
        reset         = 1'b1;
        cli_req_valid = 2'b00;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        mem_q.delete();
        #1;
        chk("midrst_outstanding", 64'(outstanding_rd), 64'(0));
        chk("midrst_slot", 64'(mem_req_valid), 64'(0));
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h1234_5678;
        #1;
        chk("midrst_no_cli_valid", 64'(cli_resp_valid), 64'(0));
        chk("midrst_drop_grant", 64'(mem_resp_grant), 64'(1));
        @(negedge clk);
        mem_resp_valid = 1'b0;
        chk("midrst_resp_err", 64'(resp_err), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ami_client_mux.md
AMI_CLIENT_MUX -- requirements
Module: ami_client_mux

Interface
REQ-001 SHALL have parameter NUM_CLIENTS, default 2, number of AMI client channels (2..8).
REQ-002 SHALL have parameter ADDR_W, default 64, request address width.
REQ-003 SHALL have parameter DATA_W, default 512, request/response data width.
REQ-004 SHALL have parameter TAG_DEPTH, default 16, outstanding-read tag FIFO depth (power of 2).
REQ-005 SHALL define localparam CID_W = max(1, clog2(NUM_CLIENTS)).
REQ-006 SHALL use a single clock domain; reset is synchronous and active-high.
REQ-007 clk  in  1  clock.
REQ-008 reset  in  1  synchronous active-high reset.
REQ-009 cli_req_valid  in  NUM_CLIENTS  per-client request valid.
REQ-010 cli_req_is_write  in  NUM_CLIENTS  per-client write flag.
REQ-011 cli_req_addr  in  NUM_CLIENTS*ADDR_W  flattened addresses; client i at bits [i*ADDR_W +: ADDR_W].
REQ-012 cli_req_data  in  NUM_CLIENTS*DATA_W  flattened write data.
REQ-013 cli_req_grant  out  NUM_CLIENTS  one-hot accept; request transfers when valid&grant.
REQ-014 cli_resp_valid  out  NUM_CLIENTS  one-hot read-response valid.
REQ-015 cli_resp_data  out  DATA_W  shared response data.
REQ-016 cli_resp_grant  in  NUM_CLIENTS  per-client response accept.
REQ-017 mem_req_valid / mem_req_is_write / mem_req_addr / mem_req_data  out  1/1/ADDR_W/DATA_W  memory-port request.
REQ-018 mem_req_grant  in  1  memory accepts request this cycle.
REQ-019 mem_resp_valid / mem_resp_data  in  1/DATA_W  memory read response (in order).
REQ-020 mem_resp_grant  out  1  response consumed.
REQ-021 outstanding_rd  out  clog2(TAG_DEPTH)+1  reads issued, not yet returned.
REQ-022 resp_err  out  1  sticky: response arrived with empty tag FIFO.
REQ-023 perf_rd_cnt / perf_wr_cnt / perf_stall_cnt  out  32 each  performance counters.

Function
REQ-024 SHALL hold one registered request slot driving mem_req_*; slot loads when empty or draining (mem_req_valid&mem_req_grant) in the same cycle.
REQ-025 SHALL grant at most one client per cycle, round-robin starting after the last granted client; pointer advances only on transfer.
REQ-026 SHALL mask reads from arbitration when tag FIFO holds TAG_DEPTH entries; writes still arbitrate.
REQ-027 SHALL push granted client ID into tag FIFO on each read loaded into the slot; writes push nothing.
REQ-028 Request latency: client transfer in cycle N -> mem_req_valid in N+1.
REQ-029 mem_req_* SHALL remain stable while mem_req_valid=1 and mem_req_grant=0.
REQ-030 SHALL route mem_resp to client at tag FIFO head combinationally: cli_resp_valid[head]=mem_resp_valid, mem_resp_grant=cli_resp_grant[head]; pop on mem_resp_valid&mem_resp_grant.
REQ-031 Simultaneous push and pop SHALL keep occupancy unchanged; pop-then-full condition re-enables reads next cycle, not same cycle.
REQ-032 outstanding_rd SHALL equal tag FIFO occupancy.
REQ-033 mem_resp_valid with empty FIFO SHALL set resp_err, assert mem_resp_grant (drop), drive no cli_resp_valid.
REQ-034 No client SHALL be granted twice in a row while another requesting eligible client waits.

Reset
REQ-035 On reset: slot empty, mem_req_valid=0, all grants 0, cli_resp_valid=0, tag FIFO empty, outstanding_rd=0, RR pointer=0 (client 0 highest priority), resp_err=0, counters 0.
REQ-036 Reset mid-operation SHALL discard slot and in-flight tags; responses arriving after reset set resp_err.

Configuration
REQ-037 With AMI_MUX_PERF_EN defined: perf_rd_cnt/perf_wr_cnt increment per mem-port read/write accepted; perf_stall_cnt increments per cycle mem_req_valid=1 and mem_req_grant=0; all saturate at 2^32-1.
REQ-038 Without AMI_MUX_PERF_EN: perf outputs SHALL be constant 0; no counter logic.

Verification
REQ-039 Clients 0,1 both request reads continuously, mem_req_grant=1 -> grants alternate 0,1,0,1; responses return to 0,1,0,1.
REQ-040 TAG_DEPTH=4, client 0 issues 4 reads, no responses -> outstanding_rd=4, further reads not granted; client 1 write still granted.
REQ-041 mem_req_grant held 0 for 5 cycles with read pending -> mem_req_addr/data stable; perf_stall_cnt=5 with AMI_MUX_PERF_EN, 0 without.
REQ-042 Response for client 1 with cli_resp_grant[1]=0 for 3 cycles -> mem_resp_grant=0, no pop; pop on 4th cycle.
REQ-043 mem_resp_valid=1 after reset with no reads issued -> resp_err=1 and stays 1 until reset.
REQ-044 Reset asserted with 3 reads outstanding -> outstanding_rd=0, mem_req_valid=0 the next cycle.
